// File: rtl/dmem_ctrl_pkg.sv
// Shared types and defaults for the memory-stage data-cache access controller.
// Contents: bus widths, default TIMEOUT / counter width, FSM state encoding,
// fault cause codes and the packed request payload held while the cache is busy.
package dmem_ctrl_pkg;

  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned DATA_W          = 16;
  localparam int unsigned DEFAULT_TIMEOUT = 64;
  localparam int unsigned DEFAULT_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } ctrlState_t;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'd0,
    CAUSE_UNALIGNED = 2'd1,
    CAUSE_RDWR      = 2'd2,
    CAUSE_TIMEOUT   = 2'd3
  } errCause_t;

  // Request captured at BUSY entry so mem_* stay glitch-free while waiting.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } memReq_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
// Ports: clk, rst (async active-low), inc (count enable), cnt (W-bit value).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage access controller between EX/MEM and a multi-cycle data cache.
// Issues one cache access per load/store, stalls the pipeline until the cache
// reports done, returns load data to MEM/WB, holds halt back while an access is
// outstanding, and keeps saturating request/hit counters.
// Ports:
//   clk, rst (async active-low)
//   ex_rd/ex_wr/ex_halt/ex_addr/ex_wdata : EX/MEM instruction fields
//   mem_req/mem_wr/mem_addr/mem_wdata    : cache request (strobe + payload)
//   mem_done/mem_hit/mem_rdata           : cache completion
//   stall, ld_data, halt_out             : pipeline control / MEM/WB data
//   dc_req, dc_hit, req_cnt, hit_cnt     : trace pulses and perf counters
//   err                                  : sticky fault, cleared only by reset
// The issue cycle and completion cycle are decided combinationally so a
// zero-wait hit costs no stall; everything else decodes registered state.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_rd,
  input  logic              ex_wr,
  input  logic              ex_halt,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic              mem_hit,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] ld_data,
  output logic              halt_out,
  output logic              dc_req,
  output logic              dc_hit,
  output logic [CNT_W-1:0]  req_cnt,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic              err
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT);

  ctrlState_t        state, stateNext;
  logic [TCNT_W-1:0] tcnt, tcntNext;
  memReq_t           held, heldNext;
  logic              heldRd, heldRdNext;
  errCause_t         cause;
  logic              access;

  // State, timeout counter and captured request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      tcnt   <= '0;
      held   <= '0;
      heldRd <= 1'b0;
    end else begin
      state  <= stateNext;
      tcnt   <= tcntNext;
      held   <= heldNext;
      heldRd <= heldRdNext;
    end
  end

  assign access = ex_rd | ex_wr;

  // Next-state and output decode.
  always_comb begin
    stateNext  = state;
    tcntNext   = tcnt;
    heldNext   = held;
    heldRdNext = heldRd;
    cause      = CAUSE_NONE;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    stall      = 1'b0;
    ld_data    = '0;
    halt_out   = 1'b0;
    dc_req     = 1'b0;
    dc_hit     = 1'b0;
    err        = 1'b0;

    case (state)
      IDLE: begin
        // Halt may only retire when nothing is being issued this cycle.
        halt_out = ex_halt & ~access;
        if (access) begin
          if (ex_addr[0]) begin
            cause = CAUSE_UNALIGNED;
          end else if (ex_rd && ex_wr) begin
            cause = CAUSE_RDWR;
          end

          if (cause != CAUSE_NONE) begin
            // Faulting access is never issued; keep it from retiring.
            stall     = 1'b1;
            stateNext = ERR;
          end else begin
            mem_req   = 1'b1;
            dc_req    = 1'b1;
            mem_wr    = ex_wr;
            mem_addr  = ex_addr;
            mem_wdata = ex_wdata;
            if (mem_done) begin
              dc_hit  = mem_hit;
              ld_data = ex_rd ? mem_rdata : '0;
            end else begin
              stall      = 1'b1;
              stateNext  = BUSY;
              // The issue cycle counts toward the timeout budget.
              tcntNext   = TCNT_W'(1);
              heldNext   = '{wr: ex_wr, addr: ex_addr, wdata: ex_wdata};
              heldRdNext = ex_rd;
            end
          end
        end
      end

      BUSY: begin
        mem_wr    = held.wr;
        mem_addr  = held.addr;
        mem_wdata = held.wdata;
        if (mem_done) begin
          dc_hit    = mem_hit;
          ld_data   = heldRd ? mem_rdata : '0;
          stateNext = IDLE;
          tcntNext  = '0;
        end else begin
          stall = 1'b1;
          if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
            cause     = CAUSE_TIMEOUT;
            stateNext = ERR;
          end else begin
            tcntNext = tcnt + TCNT_W'(1);
          end
        end
      end

      ERR: begin
        err   = 1'b1;
        stall = 1'b1;
      end

      default: begin
        err       = 1'b1;
        stall     = 1'b1;
        stateNext = ERR;
      end
    endcase

    // Outputs are quiet for the whole time reset is held.
    if (!rst) begin
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      stall     = 1'b0;
      ld_data   = '0;
      halt_out  = 1'b0;
      dc_req    = 1'b0;
      dc_hit    = 1'b0;
      err       = 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_reqCnt (
    .clk (clk),
    .rst (rst),
    .inc (dc_req),
    .cnt (req_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hitCnt (
    .clk (clk),
    .rst (rst),
    .inc (dc_hit),
    .cnt (hit_cnt)
  );

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a TIMEOUT=8 instance with 16-bit
// counters, plus a CNT_W=2 instance sharing the same stimulus for saturation.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_rd, ex_wr, ex_halt;
  logic [15:0] ex_addr, ex_wdata;
  logic        mem_done, mem_hit;
  logic [15:0] mem_rdata;

  logic        mem_req, mem_wr, stall, halt_out, dc_req, dc_hit, err;
  logic [15:0] mem_addr, mem_wdata, ld_data, req_cnt, hit_cnt;

  logic        s_mem_req, s_mem_wr, s_stall, s_halt_out, s_dc_req, s_dc_hit, s_err;
  logic [15:0] s_mem_addr, s_mem_wdata, s_ld_data;
  logic [1:0]  s_req_cnt, s_hit_cnt;

  int nChk = 0;
  int nFail = 0;
  int reqSeen = 0;
  int reqBase;

  always #5 clk = ~clk;

  always @(posedge clk) if (rst && mem_req) reqSeen++;

  dmem_access_ctrl #(.TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_halt(ex_halt), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_hit(mem_hit), .mem_rdata(mem_rdata),
    .stall(stall), .ld_data(ld_data), .halt_out(halt_out),
    .dc_req(dc_req), .dc_hit(dc_hit), .req_cnt(req_cnt), .hit_cnt(hit_cnt), .err(err)
  );

  dmem_access_ctrl #(.TIMEOUT(8), .CNT_W(2)) dutSat (
    .clk(clk), .rst(rst),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_halt(ex_halt), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .mem_req(s_mem_req), .mem_wr(s_mem_wr), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_done(mem_done), .mem_hit(mem_hit), .mem_rdata(mem_rdata),
    .stall(s_stall), .ld_data(s_ld_data), .halt_out(s_halt_out),
    .dc_req(s_dc_req), .dc_hit(s_dc_hit), .req_cnt(s_req_cnt), .hit_cnt(s_hit_cnt), .err(s_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idleIn();
    ex_rd = 0; ex_wr = 0; ex_halt = 0; ex_addr = 0; ex_wdata = 0;
    mem_done = 0; mem_hit = 0; mem_rdata = 0;
  endtask

  task automatic doReset();
    rst = 0;
    tick();
    rst = 1;
    tick();
  endtask

  initial begin
    idleIn();
    rst = 0;
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_err", err, 0);
    chk("rst_req_cnt", req_cnt, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_ld_data", ld_data, 0);
    tick();
    rst = 1;
    tick();

    // Zero-wait load hit
    ex_rd = 1; ex_addr = 16'h0010; mem_done = 1; mem_hit = 1; mem_rdata = 16'hBEEF;
    settle();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_wr", mem_wr, 0);
    chk("t1_mem_addr", mem_addr, 16'h0010);
    chk("t1_stall", stall, 0);
    chk("t1_ld_data", ld_data, 16'hBEEF);
    chk("t1_dc_req", dc_req, 1);
    chk("t1_dc_hit", dc_hit, 1);
    tick();
    idleIn();
    settle();
    chk("t1_req_cnt", req_cnt, 1);
    chk("t1_hit_cnt", hit_cnt, 1);
    chk("t1_ld_idle", ld_data, 0);
    chk("t1_stall_idle", stall, 0);

    // Store with 4-cycle miss
    tick();
    ex_wr = 1; ex_addr = 16'h0020; ex_wdata = 16'h1234;
    settle();
    chk("t2_mem_req", mem_req, 1);
    chk("t2_mem_wr", mem_wr, 1);
    chk("t2_mem_addr", mem_addr, 16'h0020);
    chk("t2_mem_wdata", mem_wdata, 16'h1234);
    chk("t2_stall0", stall, 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      settle();
      chk("t2_busy_stall", stall, 1);
      chk("t2_busy_req", mem_req, 0);
      chk("t2_busy_addr", mem_addr, 16'h0020);
      chk("t2_busy_wdata", mem_wdata, 16'h1234);
    end
    tick();
    mem_done = 1; mem_hit = 0; mem_rdata = 16'hFFFF;
    settle();
    chk("t2_done_stall", stall, 0);
    chk("t2_done_hit", dc_hit, 0);
    chk("t2_done_ld", ld_data, 0);
    tick();
    idleIn();
    settle();
    chk("t2_req_cnt", req_cnt, 2);
    chk("t2_hit_cnt", hit_cnt, 1);

    // Back-to-back loads, 3-cycle misses each
    reqBase = reqSeen;
    tick();
    ex_rd = 1; ex_addr = 16'h0002;
    settle();
    chk("t3a_mem_req", mem_req, 1);
    chk("t3a_stall", stall, 1);
    for (int k = 1; k <= 2; k++) begin
      tick();
      settle();
      chk("t3a_busy_req", mem_req, 0);
      chk("t3a_busy_stall", stall, 1);
    end
    tick();
    mem_done = 1; mem_rdata = 16'hAAAA;
    settle();
    chk("t3a_done_req", mem_req, 0);
    chk("t3a_done_stall", stall, 0);
    chk("t3a_ld_data", ld_data, 16'hAAAA);
    tick();
    mem_done = 0; mem_rdata = 0; ex_addr = 16'h0004;
    settle();
    chk("t3b_mem_req", mem_req, 1);
    chk("t3b_mem_addr", mem_addr, 16'h0004);
    for (int k = 1; k <= 2; k++) begin
      tick();
      settle();
      chk("t3b_busy_req", mem_req, 0);
      chk("t3b_busy_stall", stall, 1);
    end
    tick();
    mem_done = 1; mem_rdata = 16'h5555;
    settle();
    chk("t3b_ld_data", ld_data, 16'h5555);
    chk("t3b_done_req", mem_req, 0);
    tick();
    idleIn();
    settle();
    chk("t3_req_pulses", reqSeen - reqBase, 2);
    chk("t3_req_cnt", req_cnt, 4);
    chk("t3_hit_cnt", hit_cnt, 1);

    // Halt held behind a 5-cycle store
    tick();
    ex_wr = 1; ex_halt = 1; ex_addr = 16'h0030; ex_wdata = 16'h55AA;
    settle();
    chk("t4_issue_halt", halt_out, 0);
    chk("t4_issue_req", mem_req, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      settle();
      chk("t4_busy_halt", halt_out, 0);
      chk("t4_busy_stall", stall, 1);
    end
    tick();
    mem_done = 1;
    settle();
    chk("t4_done_halt", halt_out, 0);
    chk("t4_done_stall", stall, 0);
    tick();
    idleIn();
    ex_halt = 1;
    settle();
    chk("t4_halt_retire", halt_out, 1);
    chk("t4_req_cnt", req_cnt, 5);
    chk("t4_hit_cnt", hit_cnt, 1);

    // Unaligned load faults
    tick();
    idleIn();
    ex_rd = 1; ex_addr = 16'h0003;
    settle();
    chk("t5_no_req", mem_req, 0);
    chk("t5_no_dcreq", dc_req, 0);
    chk("t5_err_early", err, 0);
    tick();
    mem_done = 1; mem_hit = 1; mem_rdata = 16'h7777;
    settle();
    chk("t5_err", err, 1);
    chk("t5_stall", stall, 1);
    chk("t5_halt", halt_out, 0);
    chk("t5_ld_ignored", ld_data, 0);
    chk("t5_hit_ignored", dc_hit, 0);
    tick();
    tick();
    settle();
    chk("t5_err_sticky", err, 1);
    rst = 0;
    #1;
    chk("t5_rst_err", err, 0);
    chk("t5_rst_stall", stall, 0);
    chk("t5_rst_cnt", req_cnt, 0);
    idleIn();
    tick();
    rst = 1;
    tick();

    // Simultaneous read and write faults
    ex_rd = 1; ex_wr = 1; ex_addr = 16'h0008;
    settle();
    chk("t6_no_req", mem_req, 0);
    tick();
    settle();
    chk("t6_err", err, 1);
    chk("t6_stall", stall, 1);
    idleIn();
    doReset();

    // Timeout with TIMEOUT=8
    ex_rd = 1; ex_addr = 16'h0040;
    settle();
    chk("t7_issue", mem_req, 1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      settle();
      chk("t7_no_err_yet", err, 0);
      chk("t7_stall", stall, 1);
    end
    tick();
    settle();
    chk("t7_err", err, 1);
    idleIn();
    doReset();

    // Reset while busy; stray done afterwards ignored
    ex_rd = 1; ex_addr = 16'h0050;
    tick();
    settle();
    chk("t8_busy_stall", stall, 1);
    rst = 0;
    mem_done = 1; mem_hit = 1; mem_rdata = 16'hDEAD;
    #1;
    chk("t8_rst_req", mem_req, 0);
    chk("t8_rst_stall", stall, 0);
    chk("t8_rst_ld", ld_data, 0);
    chk("t8_rst_hit", dc_hit, 0);
    chk("t8_rst_addr", mem_addr, 0);
    tick();
    ex_rd = 0;
    rst = 1;
    settle();
    chk("t8_stray_hit", dc_hit, 0);
    chk("t8_stray_ld", ld_data, 0);
    chk("t8_stray_stall", stall, 0);
    tick();
    idleIn();
    settle();
    chk("t8_req_cnt", req_cnt, 0);
    chk("t8_hit_cnt", hit_cnt, 0);

    // Five zero-wait hits: 2-bit counters saturate at 3
    for (int i = 0; i < 5; i++) begin
      ex_rd = 1; ex_addr = 16'h0010; mem_done = 1; mem_hit = 1; mem_rdata = 16'(16'h0100 + i);
      settle();
      chk("t9_ld_data", ld_data, 32'(16'h0100 + i));
      tick();
    end
    idleIn();
    settle();
    chk("t9_sat_req", s_req_cnt, 3);
    chk("t9_sat_hit", s_hit_cnt, 3);
    chk("t9_wide_req", req_cnt, 5);
    chk("t9_wide_hit", hit_cnt, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
